// File: rtl/aem_pkg.sv
// Shared definitions for the adder error monitor: FSM state encoding and
// constants selecting whether prop/gen outputs are compared.
package aem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int TYPE_NOPG = 0;
   localparam int TYPE_PG   = 1;

endpackage

// File: rtl/aem_abs_diff.sv
// Combinational absolute difference |x - y| of two unsigned W-bit values,
// formed through a (W+1)-bit signed difference so the negate never wraps.
module aem_abs_diff #(
   parameter int W = 257
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] d
);

   logic [W:0] diff;

   always_comb begin
      diff = {1'b0, x} - {1'b0, y};
      d    = diff[W] ? W'(-diff) : diff[W-1:0];
   end

endmodule

// File: rtl/adder_error_monitor.sv
// Two-stage result checker comparing a DUV adder against a reference adder and
// accumulating error count, maximum error distance and saturating distance sum.
module adder_error_monitor
   import aem_pkg::*;
#(
   parameter int N     = 256,
   parameter int TYPE  = TYPE_PG,
   parameter int CNT_W = 32,
   parameter int SUM_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             valid,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [N-1:0]     s_ref,
   input  logic             cout_ref,
   input  logic             prop_ref,
   input  logic             gen_ref,
   input  logic [N-1:0]     s_duv,
   input  logic             cout_duv,
   input  logic             prop_duv,
   input  logic             gen_duv,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] pg_err_cnt,
   output logic [N:0]       max_ed,
   output logic [SUM_W-1:0] sum_ed,
   output logic             sum_sat,
   output logic [CNT_W-1:0] first_err,
   output logic             first_vld,
   output logic             busy,
   output logic             done
);

   localparam int W     = N + 1;
   localparam int ACC_W = ((SUM_W > W) ? SUM_W : W) + 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] acc_q, acc_d;

   logic             s1_vld_q, s1_vld_d;
   logic [W-1:0]     s1_x_q, s1_x_d;
   logic [W-1:0]     s1_y_q, s1_y_d;
   logic             s1_eq_q, s1_eq_d;
   logic             s1_pg_eq_q, s1_pg_eq_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] pg_err_q, pg_err_d;
   logic [W-1:0]     max_q, max_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             sat_q, sat_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             fvld_q, fvld_d;

   logic             accept;
   logic [W-1:0]     ed;
   logic [ACC_W-1:0] sum_wide;

   aem_abs_diff #(.W(W)) u_abs_diff (
      .x (s1_x_q),
      .y (s1_y_q),
      .d (ed)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first; a path that skipped one would infer a latch.
      state_d    = state_q;
      num_d      = num_q;
      acc_d      = acc_q;
      s1_vld_d   = 1'b0;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s1_eq_d    = s1_eq_q;
      s1_pg_eq_d = s1_pg_eq_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      pg_err_d   = pg_err_q;
      max_d      = max_q;
      sum_d      = sum_q;
      sat_d      = sat_q;
      first_d    = first_q;
      fvld_d     = fvld_q;
      accept     = 1'b0;
      sum_wide   = ACC_W'(sum_q) + ACC_W'(ed);

      case (state_q)
         S_IDLE: begin
            if (valid) begin
               num_d = num_samples;
               if (num_samples == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  accept  = 1'b1;
               end
            end
         end
         S_RUN: begin
            // Only num_samples are admitted, so the counters can never run past the run length.
            if (valid && (acc_q < num_q)) accept = 1'b1;
         end
         default: ;
      endcase

      if (accept) begin
         acc_d      = acc_q + CNT_W'(1);
         s1_vld_d   = 1'b1;
         s1_x_d     = {cout_ref, s_ref};
         s1_y_d     = {cout_duv, s_duv};
         s1_eq_d    = ({cout_ref, s_ref} == {cout_duv, s_duv});
         s1_pg_eq_d = (prop_ref == prop_duv) && (gen_ref == gen_duv);
      end

      if (s1_vld_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (!s1_eq_q) begin
            err_d = err_q + CNT_W'(1);
            if (!fvld_q) begin
               first_d = cnt_q;
               fvld_d  = 1'b1;
            end
         end
         if ((TYPE == TYPE_PG) && !s1_pg_eq_q) pg_err_d = pg_err_q + CNT_W'(1);
         if (ed > max_q) max_d = ed;
         if (sum_wide[ACC_W-1:SUM_W] != '0) begin
            sum_d = '1;
            sat_d = 1'b1;
         end else begin
            sum_d = sum_wide[SUM_W-1:0];
         end
         if (cnt_q == num_q - CNT_W'(1)) state_d = S_DONE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (rst || clear) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         acc_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_eq_q    <= 1'b0;
         s1_pg_eq_q <= 1'b0;
         cnt_q      <= '0;
         err_q      <= '0;
         pg_err_q   <= '0;
         max_q      <= '0;
         sum_q      <= '0;
         sat_q      <= 1'b0;
         first_q    <= '0;
         fvld_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         acc_q      <= acc_d;
         s1_vld_q   <= s1_vld_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         s1_eq_q    <= s1_eq_d;
         s1_pg_eq_q <= s1_pg_eq_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         pg_err_q   <= pg_err_d;
         max_q      <= max_d;
         sum_q      <= sum_d;
         sat_q      <= sat_d;
         first_q    <= first_d;
         fvld_q     <= fvld_d;
      end
   end

   assign sample_cnt = cnt_q;
   assign err_cnt    = err_q;
   assign pg_err_cnt = pg_err_q;
   assign max_ed     = max_q;
   assign sum_ed     = sum_q;
   assign sum_sat    = sat_q;
   assign first_err  = first_q;
   assign first_vld  = fvld_q;
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);

endmodule
